// File: rtl/hood_mode_ctrl.sv
// ---------------------------------------------------------------------------
// hood_mode_ctrl
// Range-hood mode sequencer. Handles standby and menu, SPEED_LEVELS fan
// levels, and a one-shot timed boost at level SPEED_LEVELS. It also covers a
// delayed shut-off after boost and a timed self-clean. It accumulates fan run
// seconds against a programmable cleaning-reminder threshold.
//
// Optional feature macro: HOOD_BOOST_REARM_EN
//   defined   -> a completed self-clean also re-arms the one-shot boost
//   undefined -> boost_used clears only on reset
//
// Ports:
//   clk               system clock
//   reset             asynchronous active-low reset
//   power_on          power enable; low freezes the block, clears prescaler
//   menu_pulse        single-cycle debounced menu key
//   speed_req         one-hot level request, bit k selects level k+1
//   clean_req         self-clean request level (honoured in menu only)
//   remind_limit      reminder threshold in seconds, 0 disables
//   level             active fan level, 0 = off
//   cleaning          self-clean running
//   countdown         a timed state (boost / delayed off / clean) is active
//   remain            seconds left in the current timed state
//   work_secs         accumulated run seconds (saturating)
//   cleaning_reminder sticky clean reminder
//   boost_used        one-shot boost has been consumed
// ---------------------------------------------------------------------------
module hood_mode_ctrl #(
   parameter int SPEED_LEVELS   = 3,
   parameter int LVL_W          = 2,
   parameter int TICK_DIV       = 100000000,
   parameter int BOOST_SECS     = 60,
   parameter int OFF_DELAY_SECS = 60,
   parameter int CLEAN_SECS     = 180,
   parameter int TMR_W          = 8,
   parameter int CNT_W          = 17
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    power_on,
   input  logic                    menu_pulse,
   input  logic [SPEED_LEVELS-1:0] speed_req,
   input  logic                    clean_req,
   input  logic [CNT_W-1:0]        remind_limit,
   output logic [LVL_W-1:0]        level,
   output logic                    cleaning,
   output logic                    countdown,
   output logic [TMR_W-1:0]        remain,
   output logic [CNT_W-1:0]        work_secs,
   output logic                    cleaning_reminder,
   output logic                    boost_used
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      ST_STANDBY   = 3'd0,
      ST_MENU      = 3'd1,
      ST_RUN       = 3'd2,
      ST_BOOST     = 3'd3,
      ST_DELAY_OFF = 3'd4,
      ST_CLEAN     = 3'd5
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [PW-1:0]     presc_r, presc_nxt_s;
   logic [LVL_W-1:0]  level_nxt_s;
   logic [TMR_W-1:0]  remain_nxt_s;
   logic [CNT_W-1:0]  work_nxt_s;
   logic              reminder_nxt_s;
   logic              boost_nxt_s;
   logic              tick_s;
   logic              expire_s;
   logic              load_s;
   logic              menu_s;
   logic              clean_s;
   logic [SPEED_LEVELS-1:0] req_s;
   logic              req_valid_s;
   logic              req_boost_s;
   logic [LVL_W-1:0]  req_lvl_s;

   // Converts a one-hot request into its level number (bit k -> k+1).
   function automatic logic [LVL_W-1:0] onehot_level(input logic [SPEED_LEVELS-1:0] req);
      logic [LVL_W-1:0] lvl;
      lvl = {LVL_W{1'b0}};
      for (int k = 0; k < SPEED_LEVELS; k++) begin
         lvl = lvl | (req[k] ? LVL_W'(k + 1) : {LVL_W{1'b0}});
      end
      return lvl;
   endfunction

   // Input qualification, tick generation and next-state / next-output logic.
   always_comb begin
      // Key inputs are dropped entirely while powered down.
      menu_s      = power_on & menu_pulse;
      clean_s     = power_on & clean_req;
      req_s       = power_on ? speed_req : {SPEED_LEVELS{1'b0}};
      req_valid_s = $onehot(req_s);
      req_boost_s = req_valid_s & req_s[SPEED_LEVELS-1];
      req_lvl_s   = onehot_level(req_s);

      tick_s   = power_on & (presc_r == PW'(TICK_DIV - 1));
      expire_s = tick_s & (remain == TMR_W'(1));

      state_nxt_s    = state_r;
      level_nxt_s    = level;
      boost_nxt_s    = boost_used;
      reminder_nxt_s = cleaning_reminder;
      load_s         = 1'b0;

      // Remaining time is nonzero only inside timed states.
      if (tick_s && (remain != TMR_W'(0))) begin
         remain_nxt_s = remain - TMR_W'(1);
      end else begin
         remain_nxt_s = remain;
      end

      if (tick_s && ((state_r == ST_RUN) || (state_r == ST_BOOST)) &&
          (work_secs != {CNT_W{1'b1}})) begin
         work_nxt_s = work_secs + CNT_W'(1);
      end else begin
         work_nxt_s = work_secs;
      end

      case (state_r)
         ST_STANDBY: begin
            level_nxt_s = {LVL_W{1'b0}};
            if (power_on && (remind_limit != {CNT_W{1'b0}}) && (work_secs >= remind_limit)) begin
               reminder_nxt_s = 1'b1;
            end else begin
               reminder_nxt_s = cleaning_reminder;
            end
            if (menu_s) begin
               state_nxt_s = ST_MENU;
            end else begin
               state_nxt_s = ST_STANDBY;
            end
         end
         ST_MENU, ST_RUN: begin
            if (menu_s) begin
               state_nxt_s = ST_STANDBY;
               level_nxt_s = {LVL_W{1'b0}};
            end else if (req_valid_s && !req_boost_s) begin
               state_nxt_s = ST_RUN;
               level_nxt_s = req_lvl_s;
            end else if (req_boost_s && !boost_used) begin
               state_nxt_s  = ST_BOOST;
               level_nxt_s  = LVL_W'(SPEED_LEVELS);
               boost_nxt_s  = 1'b1;
               remain_nxt_s = TMR_W'(BOOST_SECS);
               load_s       = 1'b1;
            end else if ((state_r == ST_MENU) && clean_s && (req_s == {SPEED_LEVELS{1'b0}})) begin
               state_nxt_s    = ST_CLEAN;
               level_nxt_s    = {LVL_W{1'b0}};
               reminder_nxt_s = 1'b0;
               remain_nxt_s   = TMR_W'(CLEAN_SECS);
               load_s         = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_BOOST: begin
            // A menu press wins over a coincident expiry.
            if (menu_s) begin
               state_nxt_s  = ST_DELAY_OFF;
               level_nxt_s  = {LVL_W{1'b0}};
               remain_nxt_s = TMR_W'(OFF_DELAY_SECS);
               load_s       = 1'b1;
            end else if (expire_s) begin
               state_nxt_s = ST_RUN;
               level_nxt_s = LVL_W'(SPEED_LEVELS - 1);
            end else begin
               state_nxt_s = ST_BOOST;
            end
         end
         ST_DELAY_OFF: begin
            level_nxt_s = {LVL_W{1'b0}};
            if (expire_s) begin
               state_nxt_s = ST_STANDBY;
            end else begin
               state_nxt_s = ST_DELAY_OFF;
            end
         end
         ST_CLEAN: begin
            level_nxt_s = {LVL_W{1'b0}};
            if (expire_s) begin
               state_nxt_s    = ST_STANDBY;
               work_nxt_s     = {CNT_W{1'b0}};
               reminder_nxt_s = 1'b0;
`ifdef HOOD_BOOST_REARM_EN
               boost_nxt_s    = 1'b0;
`else
               boost_nxt_s    = boost_used;
`endif
            end else begin
               state_nxt_s = ST_CLEAN;
            end
         end
         default: begin
            state_nxt_s  = ST_STANDBY;
            level_nxt_s  = {LVL_W{1'b0}};
            remain_nxt_s = {TMR_W{1'b0}};
         end
      endcase

      // Prescaler restarts on power-down, on each tick and on timed-state entry.
      if (!power_on || tick_s || load_s) begin
         presc_nxt_s = {PW{1'b0}};
      end else begin
         presc_nxt_s = presc_r + PW'(1);
      end
   end

   // State, prescaler and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r           <= ST_STANDBY;
         presc_r           <= {PW{1'b0}};
         level             <= {LVL_W{1'b0}};
         cleaning          <= 1'b0;
         countdown         <= 1'b0;
         remain            <= {TMR_W{1'b0}};
         work_secs         <= {CNT_W{1'b0}};
         cleaning_reminder <= 1'b0;
         boost_used        <= 1'b0;
      end else begin
         state_r           <= state_nxt_s;
         presc_r           <= presc_nxt_s;
         level             <= level_nxt_s;
         cleaning          <= (state_nxt_s == ST_CLEAN);
         countdown         <= (state_nxt_s == ST_BOOST) || (state_nxt_s == ST_DELAY_OFF) ||
                              (state_nxt_s == ST_CLEAN);
         remain            <= remain_nxt_s;
         work_secs         <= work_nxt_s;
         cleaning_reminder <= reminder_nxt_s;
         boost_used        <= boost_nxt_s;
      end
   end

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hood_mode_ctrl
// Directed bench for hood_mode_ctrl with TICK_DIV=4, BOOST_SECS=3,
// OFF_DELAY_SECS=2, CLEAN_SECS=5, SPEED_LEVELS=3. A vector table covers the
// run / boost / one-shot behaviour; hand sequences cover delayed off, clean
// with reminder, power freeze and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_hood_mode_ctrl;

   logic        clk;
   logic        reset;
   logic        power_on;
   logic        menu_pulse;
   logic [2:0]  speed_req;
   logic        clean_req;
   logic [16:0] remind_limit;
   logic [1:0]  level;
   logic        cleaning;
   logic        countdown;
   logic [7:0]  remain;
   logic [16:0] work_secs;
   logic        cleaning_reminder;
   logic        boost_used;

   int checks = 0;
   int errors = 0;
   int exp_bu_after_clean;

   hood_mode_ctrl #(
      .SPEED_LEVELS(3), .LVL_W(2), .TICK_DIV(4), .BOOST_SECS(3),
      .OFF_DELAY_SECS(2), .CLEAN_SECS(5), .TMR_W(8), .CNT_W(17)
   ) dut (
      .clk(clk), .reset(reset), .power_on(power_on), .menu_pulse(menu_pulse),
      .speed_req(speed_req), .clean_req(clean_req), .remind_limit(remind_limit),
      .level(level), .cleaning(cleaning), .countdown(countdown), .remain(remain),
      .work_secs(work_secs), .cleaning_reminder(cleaning_reminder),
      .boost_used(boost_used)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       menu;
      logic [2:0] spd;
      logic       cln;
      logic       pwr;
      int         ncyc;
      int         lvl, cl, cd, rem, ws, rmd, bu;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int lvl, input int cl, input int cd,
                            input int rem, input int ws, input int rmd, input int bu);
      chk({tag, "_level"}, 32'(level), lvl);
      chk({tag, "_cleaning"}, 32'(cleaning), cl);
      chk({tag, "_countdown"}, 32'(countdown), cd);
      chk({tag, "_remain"}, 32'(remain), rem);
      chk({tag, "_work_secs"}, 32'(work_secs), ws);
      chk({tag, "_reminder"}, 32'(cleaning_reminder), rmd);
      chk({tag, "_boost_used"}, 32'(boost_used), bu);
   endtask

   // Key inputs are presented for the first cycle only; power is held throughout.
   task automatic apply(input logic menu, input logic [2:0] spd, input logic cln,
                        input logic pwr, input int ncyc);
      power_on   = pwr;
      menu_pulse = menu;
      speed_req  = spd;
      clean_req  = cln;
      @(posedge clk); #1;
      menu_pulse = 1'b0;
      speed_req  = 3'b000;
      clean_req  = 1'b0;
      repeat (ncyc - 1) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      #2;
      check_all(tag, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
`ifdef HOOD_BOOST_REARM_EN
      exp_bu_after_clean = 0;
`else
      exp_bu_after_clean = 1;
`endif
      vecs[0]  = '{1'b1, 3'b000, 1'b0, 1'b1, 1,  0, 0, 0, 0, 0,  0, 0};
      vecs[1]  = '{1'b0, 3'b001, 1'b0, 1'b1, 1,  1, 0, 0, 0, 0,  0, 0};
      vecs[2]  = '{1'b0, 3'b000, 1'b0, 1'b1, 40, 1, 0, 0, 0, 10, 0, 0};
      vecs[3]  = '{1'b1, 3'b000, 1'b0, 1'b1, 1,  0, 0, 0, 0, 10, 0, 0};
      vecs[4]  = '{1'b1, 3'b000, 1'b0, 1'b1, 1,  0, 0, 0, 0, 10, 0, 0};
      vecs[5]  = '{1'b0, 3'b100, 1'b0, 1'b1, 1,  3, 0, 1, 3, 10, 0, 1};
      vecs[6]  = '{1'b0, 3'b000, 1'b0, 1'b1, 11, 3, 0, 1, 1, 12, 0, 1};
      vecs[7]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1,  2, 0, 0, 0, 13, 0, 1};
      vecs[8]  = '{1'b1, 3'b000, 1'b0, 1'b1, 1,  0, 0, 0, 0, 13, 0, 1};
      vecs[9]  = '{1'b1, 3'b000, 1'b0, 1'b1, 1,  0, 0, 0, 0, 13, 0, 1};
      vecs[10] = '{1'b0, 3'b100, 1'b0, 1'b1, 1,  0, 0, 0, 0, 13, 0, 1};
      vecs[11] = '{1'b0, 3'b010, 1'b0, 1'b1, 1,  2, 0, 0, 0, 13, 0, 1};
      vecs[12] = '{1'b0, 3'b011, 1'b0, 1'b1, 1,  2, 0, 0, 0, 13, 0, 1};
      vecs[13] = '{1'b0, 3'b001, 1'b0, 1'b1, 1,  1, 0, 0, 0, 13, 0, 1};
      vecs[14] = '{1'b0, 3'b000, 1'b0, 1'b1, 2,  1, 0, 0, 0, 14, 0, 1};
      vecs[15] = '{1'b1, 3'b000, 1'b0, 1'b1, 1,  0, 0, 0, 0, 14, 0, 1};
      vecs[16] = '{1'b0, 3'b000, 1'b0, 1'b1, 2,  0, 0, 0, 0, 14, 0, 1};
      vecs[17] = '{1'b1, 3'b000, 1'b0, 1'b1, 1,  0, 0, 0, 0, 14, 0, 1};
      vecs[18] = '{1'b0, 3'b001, 1'b1, 1'b1, 1,  1, 0, 0, 0, 14, 0, 1};
      vecs[19] = '{1'b1, 3'b000, 1'b0, 1'b1, 1,  0, 0, 0, 0, 14, 0, 1};
      vecs[20] = '{1'b0, 3'b000, 1'b1, 1'b1, 1,  0, 0, 0, 0, 14, 0, 1};

      power_on     = 1'b1;
      menu_pulse   = 1'b0;
      speed_req    = 3'b000;
      clean_req    = 1'b0;
      remind_limit = 17'd0;

      // Reset state, then run / boost auto-drop / one-shot boost vectors.
      do_reset("rst0");
      for (int i = 0; i < 21; i++) begin
         apply(vecs[i].menu, vecs[i].spd, vecs[i].cln, vecs[i].pwr, vecs[i].ncyc);
         check_all($sformatf("v%0d", i), vecs[i].lvl, vecs[i].cl, vecs[i].cd,
                   vecs[i].rem, vecs[i].ws, vecs[i].rmd, vecs[i].bu);
      end

      // Delayed off: menu press in boost at remain=2.
      do_reset("rst1");
      apply(1'b1, 3'b000, 1'b0, 1'b1, 1);
      apply(1'b0, 3'b100, 1'b0, 1'b1, 1);
      check_all("boost_entry", 3, 0, 1, 3, 0, 0, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 4);
      check_all("boost_rem2", 3, 0, 1, 2, 1, 0, 1);
      apply(1'b1, 3'b000, 1'b0, 1'b1, 1);
      check_all("doff_entry", 0, 0, 1, 2, 1, 0, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 7);
      check_all("doff_last", 0, 0, 1, 1, 1, 0, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 1);
      check_all("doff_expire", 0, 0, 0, 0, 1, 0, 1);

      // Clean and reminder, continuing with boost already consumed.
      remind_limit = 17'd5;
      apply(1'b1, 3'b000, 1'b0, 1'b1, 1);
      apply(1'b0, 3'b001, 1'b0, 1'b1, 1);
      check_all("rmd_run", 1, 0, 0, 0, 1, 0, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 24);
      check_all("rmd_run24", 1, 0, 0, 0, 7, 0, 1);
      apply(1'b1, 3'b000, 1'b0, 1'b1, 1);
      check_all("rmd_standby", 0, 0, 0, 0, 7, 0, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 1);
      check_all("rmd_set", 0, 0, 0, 0, 7, 1, 1);
      apply(1'b1, 3'b000, 1'b0, 1'b1, 1);
      check_all("rmd_menu", 0, 0, 0, 0, 7, 1, 1);
      apply(1'b0, 3'b000, 1'b1, 1'b1, 1);
      check_all("clean_entry", 0, 1, 1, 5, 7, 0, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 10);
      check_all("clean_rem3", 0, 1, 1, 3, 7, 0, 1);
      apply(1'b1, 3'b000, 1'b0, 1'b1, 1);
      check_all("clean_menu_ign", 0, 1, 1, 3, 7, 0, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 8);
      check_all("clean_rem1", 0, 1, 1, 1, 7, 0, 1);
      apply(1'b0, 3'b000, 1'b1, 1'b1, 1);
      check_all("clean_expire", 0, 0, 0, 0, 0, 0, exp_bu_after_clean);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 1);
      check_all("clean_after", 0, 0, 0, 0, 0, 0, exp_bu_after_clean);

      // Power freeze mid-boost: everything holds, prescaler restarts.
      remind_limit = 17'd0;
      do_reset("rst2");
      apply(1'b1, 3'b000, 1'b0, 1'b1, 1);
      apply(1'b0, 3'b100, 1'b0, 1'b1, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 2);
      check_all("frz_before", 3, 0, 1, 3, 0, 0, 1);
      apply(1'b1, 3'b000, 1'b0, 1'b0, 50);
      check_all("frz_hold", 3, 0, 1, 3, 0, 0, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 3);
      check_all("frz_resume3", 3, 0, 1, 3, 0, 0, 1);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 1);
      check_all("frz_resume4", 3, 0, 1, 2, 1, 0, 1);

      // Asynchronous reset in the middle of a clean.
      do_reset("rst3");
      apply(1'b1, 3'b000, 1'b0, 1'b1, 1);
      apply(1'b0, 3'b000, 1'b1, 1'b1, 1);
      check_all("clean2_entry", 0, 1, 1, 5, 0, 0, 0);
      apply(1'b0, 3'b000, 1'b0, 1'b1, 3);
      reset = 1'b0;
      #2;
      check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Parametrised range-hood mode controller, successor to the fixed three-speed mode block. It sequences standby, menu, N fan levels, a one-shot timed boost level, a delayed shut-off and a timed self-clean. It also accumulates fan run time against a programmable cleaning-reminder threshold. It sits between the debounced key front-end and the fan driver / display scanner.

## Interface
Parameters:
- SPEED_LEVELS, 3: number of fan levels; level SPEED_LEVELS is boost; must be ≥2
- LVL_W, 2: width of level output; must hold SPEED_LEVELS
- TICK_DIV, 100000000: clk cycles per one-second tick
- BOOST_SECS, 60: boost duration before auto-drop
- OFF_DELAY_SECS, 60: run-on time after menu exit from boost
- CLEAN_SECS, 180: self-clean duration
- TMR_W, 8: remaining-seconds counter width
- CNT_W, 17: work-seconds counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- power_on  in  1  power enable; low freezes the block
- menu_pulse  in  1  single-cycle debounced menu key
- speed_req  in  SPEED_LEVELS  one-hot level request; bit k selects level k+1
- clean_req  in  1  self-clean request level
- remind_limit  in  CNT_W  reminder threshold in seconds; 0 disables
- level  out  LVL_W  active fan level; 0 = off
- cleaning  out  1  self-clean running
- countdown  out  1  a timed state is active
- remain  out  TMR_W  seconds left in current timed state
- work_secs  out  CNT_W  accumulated run seconds
- cleaning_reminder  out  1  sticky clean reminder
- boost_used  out  1  boost consumed

## Operation
- States: STANDBY, MENU, RUN, BOOST, DELAY_OFF, CLEAN.
- STANDBY: menu_pulse → MENU.
- MENU:
  - menu_pulse → STANDBY.
  - Valid one-hot speed_req below boost → RUN at that level.
  - Boost bit with boost_used=0 → BOOST; boost_used set.
  - Boost bit with boost_used=1 → ignored; stay in MENU.
  - Non-one-hot speed_req → ignored.
  - clean_req with speed_req=0 → CLEAN. Speed has priority over clean.
- RUN:
  - menu_pulse → STANDBY.
  - One-hot non-boost request → level change in place.
  - Boost request → BOOST if boost_used=0; otherwise ignored.
- BOOST:
  - level = SPEED_LEVELS.
  - Expiry → RUN at level SPEED_LEVELS-1.
  - menu_pulse → DELAY_OFF.
- DELAY_OFF: level 0, fan off; expiry → STANDBY.
- CLEAN:
  - level 0; cleaning=1; menu_pulse ignored.
  - Expiry → STANDBY; clears work_secs and cleaning_reminder.
- Timed-state entry loads remain with the state's seconds parameter and zeroes the prescaler.
- Each tick decrements remain. A tick with remain=1 is expiry: remain becomes 0 and the state transitions in the same update.
- countdown = state ∈ {BOOST, DELAY_OFF, CLEAN}.
- work_secs increments on each tick in RUN or BOOST. It saturates at 2^CNT_W-1 and never wraps.
- cleaning_reminder:
  - Sets in STANDBY when remind_limit≠0 and work_secs ≥ remind_limit.
  - Clears only on CLEAN entry or reset.
- clean_req outside MENU is ignored.
- power_on=0: all registers hold, with two exceptions: the prescaler is cleared, and menu/speed/clean inputs are ignored. Rising power_on resumes from the held state.
- Simultaneous events:
  - BOOST expiry and menu_pulse in the same cycle → DELAY_OFF (menu wins).
  - CLEAN expiry and clean_req in the same cycle → STANDBY.

## Timing
- All outputs are registered.
- Reset values: level 0, cleaning 0, countdown 0, remain 0, work_secs 0, cleaning_reminder 0, boost_used 0, state STANDBY, prescaler 0.
- Input-to-output latency: a request sampled at edge n appears on state and outputs after edge n (1 cycle).
- Tick: the prescaler counts 0..TICK_DIV-1 while power_on=1; tick is the cycle at count TICK_DIV-1.
- First decrement after timed-state entry comes exactly TICK_DIV cycles later.
- A timed state lasts exactly SECS×TICK_DIV cycles.
- Reset asserted mid-operation returns all state and outputs to reset values immediately (asynchronous).

## Configuration
- HOOD_BOOST_REARM_EN defined: completing a CLEAN also clears boost_used, so boost is available again.
- HOOD_BOOST_REARM_EN undefined: boost_used clears only on reset.

## Test plan
Bench parameters: TICK_DIV=4, BOOST_SECS=3, OFF_DELAY_SECS=2, CLEAN_SECS=5, SPEED_LEVELS=3.
- Basic run: menu_pulse, then speed_req=001 → level=1 next cycle. After 40 cycles, work_secs=10. menu_pulse → level=0, STANDBY.
- Boost auto-drop: MENU, speed_req=100 → level=3, countdown=1, remain=3, boost_used=1. After 12 cycles → level=2, remain=0, countdown=0.
- One-shot boost: second MENU with speed_req=100 → stays in MENU, level 0. speed_req=010 → level=2.
- Delayed off: menu_pulse in BOOST at remain=2 → level=0, countdown=1, remain=2. After 8 cycles → STANDBY, countdown=0.
- Clean and reminder: remind_limit=5; run 24 cycles at level 1, return to STANDBY → cleaning_reminder=1. MENU + clean_req → cleaning=1, remain=5. After 20 cycles → work_secs=0, reminder=0. boost_used clears only with HOOD_BOOST_REARM_EN.
- Freeze and reset: power_on=0 mid-BOOST for 50 cycles → remain and level unchanged. Async reset mid-CLEAN → all outputs at reset values before the next clk edge.
